// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The controller (master) drives start and the operands; the subtractor (slave) returns status and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start_i;
  logic [WIDTH-1:0] data_a_i;
  logic [WIDTH-1:0] data_b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] out_o;
  logic             bout_o;

  modport master (
    output start_i, data_a_i, data_b_i,
    input  busy_o, done_o, out_o, bout_o
  );

  modport slave (
    input  start_i, data_a_i, data_b_i,
    output busy_o, done_o, out_o, bout_o
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop, LSB first,
// wrapped in a start/busy/done handshake. The result stays on the outputs until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] out_q;
  logic             bout_q;

  logic             a0;
  logic             b0;
  logic             diff_d;
  logic             borrow_d;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs; the result register fills from the MSB side.
  always_comb begin
    a0       = a_q[0];
    b0       = b_q[0];
    diff_d   = a0 ^ b0 ^ borrow_q;
    borrow_d = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);
    res_d    = {diff_d, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
      bout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            a_q      <= bus.data_a_i;
            b_q      <= bus.data_b_i;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          res_q    <= res_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + CW'(1);
          // The completing edge publishes res_d directly so the last bit is included.
          if (last_bit) begin
            out_q   <= res_d;
            bout_q  <= borrow_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.out_o  = out_q;
  assign bus.bout_o = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an operation-level model (difference, borrow, cycle budget)
// checked every cycle, plus directed cases with hand-computed results.
module tb_serial_subtractor;
  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   checkEn;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operation-level model: an accepted operation occupies WIDTH+1 cycles and
  // publishes (a-b) mod 2^WIDTH and a<b after WIDTH of them.
  int               cyclesLeft;
  logic [WIDTH-1:0] pendOut;
  logic             pendBout;
  logic [WIDTH-1:0] expOut;
  logic             expBout;
  logic             expDone;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyclesLeft = 0;
      expOut     = '0;
      expBout    = 1'b0;
      expDone    = 1'b0;
    end else if (cyclesLeft == 0) begin
      expDone = 1'b0;
      if (bus.start_i) begin
        cyclesLeft = WIDTH + 1;
        pendOut    = bus.data_a_i - bus.data_b_i;
        pendBout   = (bus.data_a_i < bus.data_b_i);
      end
    end else begin
      cyclesLeft = cyclesLeft - 1;
      expDone    = (cyclesLeft == 1);
      if (cyclesLeft == 1) begin
        expOut  = pendOut;
        expBout = pendBout;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc_busy", 32'(bus.busy_o), 32'(cyclesLeft != 0));
      checkOutput("cyc_done", 32'(bus.done_o), 32'(expDone));
      checkOutput("cyc_out",  32'(bus.out_o),  32'(expOut));
      checkOutput("cyc_bout", 32'(bus.bout_o), 32'(expBout));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Returns the number of ticks after the start edge at which done was first seen.
  task automatic waitDone(output int n);
    n = 0;
    for (int i = 1; i <= 3 * WIDTH; i++) begin
      tick();
      if (bus.done_o === 1'b1) begin
        n = i;
        return;
      end
    end
    checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] prevOut,
                               input logic [WIDTH-1:0] wantOut, input logic wantBout);
    int n;
    bus.data_a_i = a;
    bus.data_b_i = b;
    bus.start_i  = 1'b1;
    tick();
    bus.start_i = 1'b0;
    checkOutput("busy_after_start", 32'(bus.busy_o), 32'd1);
    tick();
    checkOutput("out_held", 32'(bus.out_o), 32'(prevOut));
    waitDone(n);
    // done is sampled high by the controller WIDTH+1 edges after the start edge.
    checkOutput("done_edge", 32'(n + 2), 32'(WIDTH + 1));
    checkOutput("lit_out",  32'(bus.out_o),  32'(wantOut));
    checkOutput("lit_bout", 32'(bus.bout_o), 32'(wantBout));
    tick();
    checkOutput("done_single", 32'(bus.done_o), 32'd0);
  endtask

  initial begin
    int n;
    int doneSeen;
    total        = 0;
    bad          = 0;
    checkEn      = 1'b0;
    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.data_a_i = '0;
    bus.data_b_i = '0;
    tick();
    tick();
    checkEn = 1'b1;
    checkOutput("reset_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("reset_out",  32'(bus.out_o),  32'd0);
    rst = 1'b0;
    tick();

    applyStimulus(4'b1000, 4'b0010, 4'b0000, 4'b0110, 1'b0);
    applyStimulus(4'b0010, 4'b1000, 4'b0110, 4'b1010, 1'b1);
    applyStimulus(4'b0101, 4'b0101, 4'b1010, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0001, 4'b0000, 4'b1111, 1'b1);

    // start held high; mid-RUN operand change must not disturb the first result.
    bus.data_a_i = 4'b1111;
    bus.data_b_i = 4'b0001;
    bus.start_i  = 1'b1;
    tick();
    tick();
    tick();
    bus.data_a_i = 4'b0011;
    tick();
    tick();
    checkOutput("cont_done",  32'(bus.done_o), 32'd1);
    checkOutput("cont_out",   32'(bus.out_o),  32'he);
    checkOutput("cont_bout",  32'(bus.bout_o), 32'd0);
    tick();
    checkOutput("cont_gap",   32'(bus.busy_o), 32'd0);
    tick();
    checkOutput("cont_again", 32'(bus.busy_o), 32'd1);
    bus.start_i = 1'b0;
    waitDone(n);
    checkOutput("cont2_out",  32'(bus.out_o),  32'h2);
    checkOutput("cont2_bout", 32'(bus.bout_o), 32'd0);
    tick();

    // Asynchronous abort between E2 and E3.
    bus.data_a_i = 4'b1000;
    bus.data_b_i = 4'b0010;
    bus.start_i  = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("abort_done", 32'(bus.done_o), 32'd0);
    checkOutput("abort_out",  32'(bus.out_o),  32'd0);
    checkOutput("abort_bout", 32'(bus.bout_o), 32'd0);
    tick();
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      tick();
      if (bus.done_o === 1'b1) doneSeen++;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    applyStimulus(4'b1000, 4'b0010, 4'b0000, 4'b0110, 1'b0);

    // Randomized traffic: random operands, start hold lengths, gaps and occasional resets.
    for (int k = 0; k < 40; k++) begin
      int hold;
      int gap;
      hold = int'($urandom_range(1, 8));
      gap  = int'($urandom_range(0, 3));
      bus.start_i = 1'b1;
      for (int j = 0; j < hold; j++) begin
        bus.data_a_i = WIDTH'($urandom);
        bus.data_b_i = WIDTH'($urandom);
        tick();
      end
      bus.start_i = 1'b0;
      for (int j = 0; j < gap; j++) tick();
      if ($urandom_range(0, 9) == 0) begin
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    for (int j = 0; j < WIDTH + 3; j++) tick();

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor that computes data_a − data_b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the serial adder in the same arithmetic datapath. It adds a start/busy/done handshake so a controller can sequence operands through it back-to-back. Results are held on the outputs until the next subtraction completes.

## Interface
- WIDTH, default 4: operand and result width in bits; legal values are WIDTH ≥ 2.
- clk  input  1  system clock; all state changes occur on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- data_a  input  WIDTH  minuend; sampled only on the edge that accepts start.
- data_b  input  WIDTH  subtrahend; sampled on the same edge as data_a.
- start  input  1  request to begin a subtraction; honoured only in IDLE.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse indicating that out and bout are updated.
- out  output  WIDTH  difference, equal to (data_a − data_b) mod 2^WIDTH.
- bout  output  1  final borrow; high iff data_a < data_b (unsigned).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Load shift register A←data_a and B←data_b.
  - Clear borrow and the result shift register.
  - Clear the bit counter, which has width $clog2(WIDTH+1).
  - Go to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - Form a0 = A[0], b0 = B[0], br = borrow.
  - d = a0 ^ b0 ^ br.
  - borrow ← (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift A and B right by one.
  - Shift the result register right, inserting d at the MSB.
  - Increment the counter.
- RUN, on the edge that processes bit WIDTH−1:
  - out ← final result register value (the complete difference, including that bit).
  - bout ← final borrow.
  - Go to DONE.
- DONE: done=1 for this single state; the next edge returns to IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued, and data_a/data_b changes during those states have no effect.
- out and bout are not cleared when a new subtraction starts. They change only at completion or on reset.
- All arithmetic is unsigned modulo 2^WIDTH. A two's-complement view of out is valid when the caller interprets the operands as signed; bout is the unsigned borrow regardless.

## Timing
- Reset values: state=IDLE, busy=0, done=0, out=0, bout=0. Internal shift registers, borrow and counter are all 0.
- Reset asserted at any time, including mid-RUN or in DONE: the operation is aborted and all of the above values apply immediately (asynchronously). No done pulse is produced for the aborted operation.
- Edge-by-edge sequence, with E0 the edge that samples start=1 in IDLE:
  - E1..EWIDTH each process one bit.
  - out/bout update at EWIDTH.
  - done=1 and busy=1 in the cycle between EWIDTH and EWIDTH+1.
  - EWIDTH+1 returns to IDLE, with busy=0 and done=0.
- Latency: WIDTH clock cycles from the start-accepting edge to the edge that registers the result.
- Throughput: one operation per WIDTH+2 cycles, with start held high continuously. The earliest re-accept edge is EWIDTH+2.
- busy goes high at E0 and stays high for WIDTH+1 cycles.
- done is never high for more than one cycle and is never high while state=IDLE.

## Test plan
- WIDTH=4, reset for 2 cycles, then data_a=1000, data_b=0010, start pulsed for 1 cycle:
  - done pulses exactly 5 edges after the start edge.
  - out=0110, bout=0.
- data_a=0010, data_b=1000 -> out=1010, bout=1.
- data_a=0101, data_b=0101 -> out=0000, bout=0.
- data_a=0000, data_b=0001 -> out=1111, bout=1.
  - Borrow ripples through all 4 bits.
  - The previous out value is held until this done.
- start=1 held continuously with data_a=1111, data_b=0001 for the first operation:
  - Change data_a to 0011 at E2 and assert start again during RUN.
  - Required: the first result is out=1110, bout=0, unaffected by the mid-RUN changes.
  - The next operation starts at E6 using the data present then.
  - busy low for exactly one cycle between operations.
- Start data_a=1000, data_b=0010, then assert reset asynchronously between E2 and E3:
  - busy, done, out and bout go to 0 immediately.
  - No done pulse follows.
  - After reset release, a new start completes normally.
